// File: rtl/i2c_arbiter_pkg.sv
// i2c_arbiter_pkg: shared definitions for the I2C command-port arbiter.
//   cmd_e          - byte-level controller command codes (START/WRITE/READ/STOP)
//   arb_state_e    - arbiter FSM states
//   onehot_to_idx  - converts a one-hot vector of up to MaxReq bits to a binary index
package i2c_arbiter_pkg;

  localparam int unsigned MaxReq = 8;

  typedef enum logic [1:0] {
    CmdStart = 2'd0,
    CmdWrite = 2'd1,
    CmdRead  = 2'd2,
    CmdStop  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StBusy,
    StAbort,
    StAbortWait
  } arb_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [MaxReq-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// i2c_arbiter_rr_pick: combinational round-robin picker.
//   req    [N]    - request vector
//   last   [IdxW] - index of the previous winner (lowest priority this round)
//   winner [N]    - one-hot winner, searching upward from last+1
//   valid         - at least one request is pending
module i2c_arbiter_rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic [N-1:0]    winner,
  output logic            valid
);

  logic [31:0]  shift;
  logic [N-1:0] rot;
  logic [N-1:0] rot_pick;

  // Rotate so that requester last+1 sits at bit 0, take the lowest set bit,
  // then rotate the pick back into requester order.
  assign shift    = 32'(last) + 32'd1;
  assign rot      = N'({req, req} >> shift);
  assign rot_pick = rot & (~rot + N'(1));
  assign winner   = N'(({rot_pick, rot_pick} << shift) >> N);
  assign valid    = |req;

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one byte-level I2C controller command port between N_REQ
// requesters. Grants round-robin, holds the grant until the owner's STOP
// completes, and force-closes stalled transactions with a STOP.
//   clk, rst_n                 - clock, synchronous active-low reset
//   req/start/cmd/wdata/wack   - per-requester request and command slices
//   gnt/req_ready/rdata_valid  - per-requester grant, ready and read-valid
//   aborted                    - one-cycle pulse when an owner's grant is revoked
//   rdata                      - broadcast read byte
//   ctl_*                      - controller command port
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     start,
  input  logic [2*N_REQ-1:0]   cmd,
  input  logic [8*N_REQ-1:0]   wdata,
  input  logic [N_REQ-1:0]     wack,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           rdata,
  output logic [N_REQ-1:0]     rdata_valid,
  output logic [N_REQ-1:0]     aborted,
  output logic [1:0]           ctl_cmd,
  output logic [7:0]           ctl_wdata,
  output logic                 ctl_wack,
  output logic                 ctl_start,
  input  logic                 ctl_ready,
  input  logic [7:0]           ctl_rdata,
  input  logic                 ctl_rdata_valid
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TmrW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(IDLE_TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] last_owner_q, last_owner_d;
  logic            bus_open_q, bus_open_d;
  cmd_e            last_cmd_q, last_cmd_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [N_REQ-1:0] aborted_q, aborted_d;

  logic [N_REQ-1:0] pick_winner;
  logic             pick_valid;
  logic [IdxW-1:0]  pick_idx;

  // last_owner doubles as the current owner index while a grant is held.
  logic [1:0] own_cmd;
  logic [7:0] own_wdata;
  logic       own_wack;
  logic       own_start;
  logic       own_req;
  logic       own_strobe;
  logic       timer_expired;

  i2c_arbiter_rr_pick #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req    (req),
    .last   (last_owner_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign pick_idx      = IdxW'(onehot_to_idx(MaxReq'(pick_winner)));
  assign own_cmd       = cmd[{last_owner_q, 1'b0} +: 2];
  assign own_wdata     = wdata[{last_owner_q, 3'b000} +: 8];
  assign own_wack      = wack[last_owner_q];
  assign own_start     = start[last_owner_q];
  assign own_req       = req[last_owner_q];
  assign own_strobe    = own_start & ctl_ready;
  assign timer_expired = (timer_q == TmrMax);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    bus_open_d   = bus_open_q;
    last_cmd_d   = last_cmd_q;
    timer_d      = timer_q;
    aborted_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (ctl_ready && pick_valid) begin
          gnt_d        = pick_winner;
          last_owner_d = pick_idx;
          timer_d      = '0;
          state_d      = StGrant;
        end
      end
      StGrant: begin
        // A strobe outranks both a dropped req and an expiring timer.
        if (own_strobe) begin
          last_cmd_d = cmd_e'(own_cmd);
          if (cmd_e'(own_cmd) == CmdStart) bus_open_d = 1'b1;
          timer_d = '0;
          state_d = StBusy;
        end else if (!own_req || timer_expired) begin
          if (bus_open_q) begin
            aborted_d = gnt_q;
            state_d   = StAbort;
          end else begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end else if (ctl_ready && !timer_expired) begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StBusy: begin
        if (ctl_ready) begin
          if (last_cmd_q == CmdStop) begin
            bus_open_d = 1'b0;
            gnt_d      = '0;
            state_d    = StIdle;
          end else begin
            state_d = StGrant;
          end
        end
      end
      StAbort: begin
        state_d = StAbortWait;
      end
      StAbortWait: begin
        if (ctl_ready) begin
          bus_open_d = 1'b0;
          gnt_d      = '0;
          state_d    = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      last_owner_q <= IdxW'(N_REQ - 1);
      bus_open_q   <= 1'b0;
      last_cmd_q   <= CmdStart;
      timer_q      <= '0;
      aborted_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      bus_open_q   <= bus_open_d;
      last_cmd_q   <= last_cmd_d;
      timer_q      <= timer_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    req_ready = '0;
    ctl_cmd   = '0;
    ctl_wdata = '0;
    ctl_wack  = 1'b0;
    ctl_start = 1'b0;
    unique case (state_q)
      StGrant: begin
        req_ready = gnt_q & {N_REQ{ctl_ready}};
        ctl_cmd   = own_cmd;
        ctl_wdata = own_wdata;
        ctl_wack  = own_wack;
        ctl_start = own_strobe;
      end
      StAbort: begin
        ctl_cmd   = CmdStop;
        ctl_start = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt         = gnt_q;
  assign aborted     = aborted_q;
  assign rdata       = ctl_rdata;
  assign rdata_valid = gnt_q & {N_REQ{ctl_rdata_valid}};

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: self-checking bench for i2c_arbiter with a behavioural
// controller model, directed scenarios and a randomized round-robin run.
module tb_i2c_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 16;
  localparam logic [1:0] OpStart = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpRead  = 2'd2;
  localparam logic [1:0] OpStop  = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req, start, wack;
  logic [2*N-1:0] cmd;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   gnt, req_ready, rdata_valid, aborted;
  logic [7:0]     rdata;
  logic [1:0]     ctl_cmd;
  logic [7:0]     ctl_wdata;
  logic           ctl_wack, ctl_start;
  logic           ctl_ready;
  logic [7:0]     ctl_rdata;
  logic           ctl_rdata_valid;

  int nchecks = 0;
  int nfail   = 0;
  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];

  i2c_arbiter #(
    .N_REQ        (N),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .start           (start),
    .cmd             (cmd),
    .wdata           (wdata),
    .wack            (wack),
    .gnt             (gnt),
    .req_ready       (req_ready),
    .rdata           (rdata),
    .rdata_valid     (rdata_valid),
    .aborted         (aborted),
    .ctl_cmd         (ctl_cmd),
    .ctl_wdata       (ctl_wdata),
    .ctl_wack        (ctl_wack),
    .ctl_start       (ctl_start),
    .ctl_ready       (ctl_ready),
    .ctl_rdata       (ctl_rdata),
    .ctl_rdata_valid (ctl_rdata_valid)
  );

  // Controller model: accepts a strobe while ready, stays busy 1..3 cycles,
  // returns a random byte on READ, and logs every accepted command.
  logic [1:0] busy_cnt;
  logic       pend_read;
  always @(posedge clk) begin
    if (!rst_n) begin
      ctl_ready       <= 1'b1;
      busy_cnt        <= 2'd0;
      pend_read       <= 1'b0;
      ctl_rdata_valid <= 1'b0;
      ctl_rdata       <= 8'd0;
    end else begin
      ctl_rdata_valid <= 1'b0;
      if (ctl_ready) begin
        if (ctl_start) begin
          ctl_ready <= 1'b0;
          busy_cnt  <= 2'($urandom_range(0, 2));
          pend_read <= (ctl_cmd == OpRead);
          log_q.push_back({ctl_cmd, ctl_wdata, ctl_wack});
        end
      end else if (busy_cnt == 2'd0) begin
        ctl_ready <= 1'b1;
        if (pend_read) begin
          ctl_rdata_valid <= 1'b1;
          ctl_rdata       <= 8'($urandom);
        end
      end else begin
        busy_cnt <= busy_cnt - 2'd1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; start = '0; cmd = '0; wdata = '0; wack = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Waits for the owner's ready, strobes one command and checks pass-through.
  task automatic issue(input int r, input logic [1:0] c, input logic [7:0] d, input logic a,
                       input bit noise);
    int n = 0;
    logic [N-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    while (!req_ready[r] && n < 40) begin
      step();
      n++;
    end
    nchecks++;
    if (req_ready[r] !== 1'b1) begin
      nfail++;
      $display("FAIL issue_wait_ready r=%0d: req_ready=%b required bit set", r, req_ready);
      return;
    end
    start = '0;
    start[r] = 1'b1;
    cmd[2*r +: 2] = c;
    wdata[8*r +: 8] = d;
    wack[r] = a;
    if (noise) begin
      for (int i = 0; i < N; i++) begin
        if (i != r) begin
          start[i] = 1'($urandom);
          cmd[2*i +: 2] = 2'($urandom);
          wdata[8*i +: 8] = 8'($urandom);
          wack[i] = 1'($urandom);
        end
      end
    end
    #1;
    nchecks++;
    if ({ctl_start, ctl_cmd, ctl_wdata, ctl_wack} !== {1'b1, c, d, a}) begin
      nfail++;
      $display("FAIL passthrough r=%0d: got start=%b cmd=%0d wdata=%h wack=%b want 1 %0d %h %b",
               r, ctl_start, ctl_cmd, ctl_wdata, ctl_wack, c, d, a);
    end
    exp_q.push_back({c, d, a});
    step();
    start = '0;
    if (c == OpRead) begin
      n = 0;
      while (!ctl_rdata_valid && n < 20) begin
        step();
        n++;
      end
      nchecks++;
      if (ctl_rdata_valid !== 1'b1 || rdata_valid !== oh || rdata !== ctl_rdata) begin
        nfail++;
        $display("FAIL read_return r=%0d: rdata_valid=%b rdata=%h want %b %h",
                 r, rdata_valid, rdata, oh, ctl_rdata);
      end
    end
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    while (gnt != '0 && n < 30) begin
      step();
      n++;
    end
    nchecks++;
    if (gnt !== '0) begin
      nfail++;
      $display("FAIL %s_release: gnt=%b want 000", name, gnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b011; start = '0; cmd = '0; wdata = '0; wack = '0;
    step();
    step();
    nchecks++;
    if (gnt !== '0) begin
      nfail++;
      $display("FAIL reset_gnt: gnt=%b want 000", gnt);
    end
    nchecks++;
    if ({req_ready, rdata_valid, aborted} !== '0) begin
      nfail++;
      $display("FAIL reset_flags: rr=%b rv=%b ab=%b want 0", req_ready, rdata_valid, aborted);
    end
    nchecks++;
    if ({ctl_start, ctl_cmd, ctl_wdata, ctl_wack} !== 12'd0) begin
      nfail++;
      $display("FAIL reset_ctl: start=%b cmd=%0d wdata=%h want 0", ctl_start, ctl_cmd, ctl_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n = 0;
    do_reset();
    req = 3'b001;
    nchecks++;
    if (gnt !== 3'b000) begin
      nfail++;
      $display("FAIL single_pre_gnt: gnt=%b want 000", gnt);
    end
    step();
    nchecks++;
    if (gnt !== 3'b001 || req_ready !== 3'b001) begin
      nfail++;
      $display("FAIL single_grant_latency: gnt=%b req_ready=%b want 001 001", gnt, req_ready);
    end
    issue(0, OpStart, 8'h00, 1'b0, 1'b0);
    issue(0, OpWrite, 8'hA4, 1'b0, 1'b0);
    issue(0, OpStop, 8'h00, 1'b0, 1'b0);
    while (!ctl_ready && n < 20) begin
      step();
      n++;
    end
    nchecks++;
    if (gnt !== 3'b001) begin
      nfail++;
      $display("FAIL single_hold_until_stop: gnt=%b want 001", gnt);
    end
    step();
    nchecks++;
    if (gnt !== 3'b000) begin
      nfail++;
      $display("FAIL single_release: gnt=%b want 000", gnt);
    end
    req = '0;
  endtask

  task automatic test_alternate();
    int n = 0;
    logic [N-1:0] want;
    do_reset();
    req = 3'b011;
    while (gnt == '0 && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 3'b001 : 3'b010;
      nchecks++;
      if (gnt !== want) begin
        nfail++;
        $display("FAIL alternate_grant_%0d: gnt=%b want %b", i, gnt, want);
      end
      issue(i % 2, OpStart, 8'h00, 1'b0, 1'b0);
      issue(i % 2, OpStop, 8'h00, 1'b0, 1'b0);
      wait_release("alternate");
      step();
    end
    req = '0;
  endtask

  task automatic test_read_ignore();
    int n = 0;
    do_reset();
    req = 3'b011;
    step();
    nchecks++;
    if (gnt !== 3'b001) begin
      nfail++;
      $display("FAIL readign_grant: gnt=%b want 001", gnt);
    end
    issue(0, OpStart, 8'h00, 1'b0, 1'b0);
    while (!req_ready[0] && n < 20) begin
      step();
      n++;
    end
    start = 3'b011;
    cmd   = {2'b00, OpStop, OpRead};
    wdata = {8'h00, 8'hFF, 8'h3C};
    wack  = 3'b010;
    #1;
    nchecks++;
    if (ctl_start !== 1'b1 || ctl_cmd !== OpRead || ctl_wack !== 1'b0 || ctl_wdata !== 8'h3C) begin
      nfail++;
      $display("FAIL readign_mux: start=%b cmd=%0d wack=%b wdata=%h want 1 2 0 3c",
               ctl_start, ctl_cmd, ctl_wack, ctl_wdata);
    end
    step();
    start = '0;
    n = 0;
    while (!ctl_rdata_valid && n < 20) begin
      step();
      n++;
    end
    nchecks++;
    if (rdata_valid !== 3'b001 || rdata !== ctl_rdata) begin
      nfail++;
      $display("FAIL readign_rdata_valid: rdata_valid=%b rdata=%h want 001 %h",
               rdata_valid, rdata, ctl_rdata);
    end
    nchecks++;
    if (log_q.size() == 0 || log_q[$][10:9] !== OpRead) begin
      nfail++;
      $display("FAIL readign_log: last logged cmd is not READ (size %0d)", log_q.size());
    end
    issue(0, OpStop, 8'h00, 1'b0, 1'b0);
    wait_release("readign");
    req = '0;
  endtask

  task automatic test_timeout();
    int n = 0;
    bit early = 1'b0;
    do_reset();
    req = 3'b001;
    step();
    issue(0, OpStart, 8'h00, 1'b0, 1'b0);
    while (!req_ready[0] && n < 20) begin
      step();
      n++;
    end
    for (int j = 0; j <= TO; j++) begin
      if (ctl_start !== 1'b0 || aborted !== 3'b000) early = 1'b1;
      step();
    end
    nchecks++;
    if (early) begin
      nfail++;
      $display("FAIL timeout_early: abort seen before %0d idle ready cycles elapsed", TO);
    end
    nchecks++;
    if (ctl_start !== 1'b1 || ctl_cmd !== OpStop || aborted !== 3'b001 || gnt !== 3'b001) begin
      nfail++;
      $display("FAIL timeout_abort: start=%b cmd=%0d aborted=%b gnt=%b want 1 3 001 001",
               ctl_start, ctl_cmd, aborted, gnt);
    end
    req = '0;
    step();
    nchecks++;
    if (aborted !== 3'b000 || ctl_start !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_pulse_width: aborted=%b start=%b want 000 0", aborted, ctl_start);
    end
    n = 0;
    while (!ctl_ready && n < 20) begin
      step();
      n++;
    end
    step();
    nchecks++;
    if (gnt !== 3'b000) begin
      nfail++;
      $display("FAIL timeout_release: gnt=%b want 000", gnt);
    end
    nchecks++;
    if (log_q.size() == 0 || log_q[$][10:9] !== OpStop) begin
      nfail++;
      $display("FAIL timeout_stop_logged: controller did not receive STOP");
    end
  endtask

  task automatic test_drop();
    int sz;
    bit bad = 1'b0;
    do_reset();
    req = 3'b001;
    step();
    nchecks++;
    if (gnt !== 3'b001) begin
      nfail++;
      $display("FAIL drop_grant: gnt=%b want 001", gnt);
    end
    sz = log_q.size();
    req = '0;
    step();
    nchecks++;
    if (gnt !== 3'b000) begin
      nfail++;
      $display("FAIL drop_release: gnt=%b want 000", gnt);
    end
    for (int j = 0; j < 4; j++) begin
      if (aborted !== 3'b000 || ctl_start !== 1'b0) bad = 1'b1;
      step();
    end
    nchecks++;
    if (bad || log_q.size() != sz) begin
      nfail++;
      $display("FAIL drop_no_stop: aborted/stop seen, log grew %0d -> %0d", sz, log_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b011;
    step();
    issue(0, OpStart, 8'h00, 1'b0, 1'b0);
    issue(0, OpWrite, 8'h5C, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    nchecks++;
    if ({gnt, req_ready, aborted, rdata_valid} !== '0) begin
      nfail++;
      $display("FAIL resetmid_outputs: gnt=%b rr=%b ab=%b rv=%b want 0",
               gnt, req_ready, aborted, rdata_valid);
    end
    nchecks++;
    if ({ctl_start, ctl_cmd, ctl_wdata, ctl_wack} !== 12'd0) begin
      nfail++;
      $display("FAIL resetmid_ctl: start=%b cmd=%0d wdata=%h wack=%b want 0",
               ctl_start, ctl_cmd, ctl_wdata, ctl_wack);
    end
    step();
    nchecks++;
    if (gnt !== 3'b001) begin
      nfail++;
      $display("FAIL resetmid_regrant: gnt=%b want 001", gnt);
    end
    req = '0;
    step();
    nchecks++;
    if (gnt !== 3'b000 || aborted !== 3'b000) begin
      nfail++;
      $display("FAIL resetmid_clean_release: gnt=%b aborted=%b want 000 000", gnt, aborted);
    end
  endtask

  function automatic int rr_model(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic test_random();
    int model_last = N - 1;
    int pred;
    int n;
    int nops;
    logic [N-1:0] mask;
    logic [N-1:0] oh;
    do_reset();
    log_q.delete();
    exp_q.delete();
    for (int rnd = 0; rnd < 12; rnd++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      req = mask;
      pred = rr_model(model_last, mask);
      oh = '0;
      oh[pred] = 1'b1;
      n = 0;
      while (gnt == '0 && n < 20) begin
        step();
        n++;
      end
      nchecks++;
      if (gnt !== oh) begin
        nfail++;
        $display("FAIL random_grant_%0d: gnt=%b want %b (req=%b)", rnd, gnt, oh, mask);
      end
      issue(pred, OpStart, 8'($urandom), 1'($urandom), 1'b1);
      nops = $urandom_range(0, 3);
      for (int j = 0; j < nops; j++) begin
        issue(pred, ($urandom_range(0, 1) == 0) ? OpWrite : OpRead, 8'($urandom),
              1'($urandom), 1'b1);
      end
      issue(pred, OpStop, 8'($urandom), 1'($urandom), 1'b1);
      wait_release("random");
      model_last = pred;
    end
    req = '0;
    step();
    nchecks++;
    if (log_q.size() != exp_q.size()) begin
      nfail++;
      $display("FAIL random_cmd_count: got %0d commands want %0d", log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        nchecks++;
        if (log_q[i] !== exp_q[i]) begin
          nfail++;
          $display("FAIL random_cmd_%0d: got %h want %h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req = '0; start = '0; cmd = '0; wdata = '0; wack = '0;
    test_reset();
    test_single();
    test_alternate();
    test_read_ignore();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
